// File: rtl/prio_index_decoder.sv
// Index-to-one-hot decoder with a small valid/ready FIFO; out-of-range indices are consumed and flagged.
// Optional saturating error counter (err_count/err_clr) enabled by defining PRIO_DEC_ERR_CNT_EN.
module prio_index_decoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IDX_W-1:0]           in_idx,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_onehot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
`ifdef PRIO_DEC_ERR_CNT_EN
  input  logic                       err_clr,
  output logic [7:0]                 err_count,
`endif
  output logic                       err_pulse
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             in_range;
  logic             push;
  logic             store;
  logic             pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  // Held low through reset so nothing is accepted until rst_n releases.
  assign in_ready = rst_n && !full;
  assign out_valid = !empty;

  // One extra bit keeps the compare meaningful when WIDTH == 2**IDX_W.
  assign in_range = ({1'b0, in_idx} < (IDX_W + 1)'(WIDTH));
  assign push     = in_valid && in_ready;
  assign store    = push && in_range;
  assign pop      = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      err_pulse <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (store && !pop)      level <= level + 1'b1;
      else if (!store && pop) level <= level - 1'b1;
      err_pulse <= push && !in_range;
    end
  end

  // NOTE: storage is not reset; level gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_idx;
  end

  // NOTE: default assignment first so the combinational block cannot infer a latch.
  always_comb begin
    out_onehot = '0;
    if (!empty) out_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << mem[rd_ptr];
  end

`ifdef PRIO_DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_count <= '0;
    else if (err_clr)                       err_count <= '0;
    else if (err_pulse && err_count != '1)  err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_prio_index_decoder.sv
// Scoreboard bench for prio_index_decoder: an 8-wide instance (a) and a 6-wide instance (b) driven in lockstep.
module tb_prio_index_decoder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [2:0] a_in_idx, b_in_idx;
  logic       a_in_valid, b_in_valid;
  logic       a_in_ready, b_in_ready;
  logic [7:0] a_out_onehot;
  logic [5:0] b_out_onehot;
  logic       a_out_valid, b_out_valid;
  logic       a_out_ready, b_out_ready;
  logic [1:0] a_level, b_level;
  logic       a_err_pulse, b_err_pulse;
`ifdef PRIO_DEC_ERR_CNT_EN
  logic       a_err_clr, b_err_clr;
  logic [7:0] a_err_count, b_err_count;
  int         exp_cnt_b;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] qa[$];
  logic [5:0] qb[$];
  logic       exp_err_b;

  always #5 clk = ~clk;

  prio_index_decoder #(.WIDTH(8), .IDX_W(3), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_idx(a_in_idx), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_onehot(a_out_onehot), .out_valid(a_out_valid), .out_ready(a_out_ready), .level(a_level),
`ifdef PRIO_DEC_ERR_CNT_EN
    .err_clr(a_err_clr), .err_count(a_err_count),
`endif
    .err_pulse(a_err_pulse)
  );

  prio_index_decoder #(.WIDTH(6), .IDX_W(3), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_idx(b_in_idx), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_onehot(b_out_onehot), .out_valid(b_out_valid), .out_ready(b_out_ready), .level(b_level),
`ifdef PRIO_DEC_ERR_CNT_EN
    .err_clr(b_err_clr), .err_count(b_err_count),
`endif
    .err_pulse(b_err_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output of both instances against the model state.
  task automatic check_state();
    check("a_level",   32'(a_level), 32'(qa.size()));
    check("a_valid",   32'(a_out_valid), 32'(qa.size() != 0));
    check("a_ready",   32'(a_in_ready), 32'(qa.size() < 2));
    check("a_onehot",  32'(a_out_onehot), (qa.size() != 0) ? 32'(qa[0]) : 32'h0);
    check("a_err",     32'(a_err_pulse), 32'h0);
    check("b_level",   32'(b_level), 32'(qb.size()));
    check("b_valid",   32'(b_out_valid), 32'(qb.size() != 0));
    check("b_ready",   32'(b_in_ready), 32'(qb.size() < 2));
    check("b_onehot",  32'(b_out_onehot), (qb.size() != 0) ? 32'(qb[0]) : 32'h0);
    check("b_err",     32'(b_err_pulse), 32'(exp_err_b));
`ifdef PRIO_DEC_ERR_CNT_EN
    check("b_err_count", 32'(b_err_count), 32'(exp_cnt_b));
`endif
  endtask

  // One clock: pop heads are compared before the edge, accepted pushes enter the scoreboard at the edge.
  task automatic tick();
    bit acc_a, pop_a, acc_b, pop_b;
    acc_a = a_in_valid && (qa.size() < 2);
    pop_a = a_out_ready && (qa.size() != 0);
    acc_b = b_in_valid && (qb.size() < 2);
    pop_b = b_out_ready && (qb.size() != 0);
    if (pop_a) check("a_pop_head", 32'(a_out_onehot), 32'(qa[0]));
    if (pop_b) check("b_pop_head", 32'(b_out_onehot), 32'(qb[0]));
    @(posedge clk);
    if (pop_a) qa.delete(0);
    if (acc_a && int'(a_in_idx) < 8) qa.push_back(8'd1 << a_in_idx);
    if (pop_b) qb.delete(0);
    if (acc_b && int'(b_in_idx) < 6) qb.push_back(6'd1 << b_in_idx);
`ifdef PRIO_DEC_ERR_CNT_EN
    if (b_err_clr)                          exp_cnt_b = 0;
    else if (exp_err_b && exp_cnt_b < 255)  exp_cnt_b = exp_cnt_b + 1;
`endif
    exp_err_b = acc_b && (int'(b_in_idx) >= 6);
    #1;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_idx = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_idx = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    exp_err_b = 1'b0;
`ifdef PRIO_DEC_ERR_CNT_EN
    a_err_clr = 1'b0; b_err_clr = 1'b0; exp_cnt_b = 0;
`endif

    // Reset state, in_ready held low during reset.
    #12;
    check("rst_a_ready",  32'(a_in_ready), 32'h0);
    check("rst_a_valid",  32'(a_out_valid), 32'h0);
    check("rst_a_level",  32'(a_level), 32'h0);
    check("rst_a_onehot", 32'(a_out_onehot), 32'h0);
    check("rst_b_err",    32'(b_err_pulse), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel_a_ready", 32'(a_in_ready), 32'h1);
    tick();

    // Single push of 5, held while out_ready is low, then popped.
    a_in_idx = 3'd5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("push5_onehot", 32'(a_out_onehot), 32'h20);
    repeat (3) tick();
    check("hold5_onehot", 32'(a_out_onehot), 32'h20);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("pop5_valid", 32'(a_out_valid), 32'h0);

    // Fill with 3 and 7, third push refused, then drain.
    a_in_valid = 1'b1; a_in_idx = 3'd3; tick();
    a_in_idx = 3'd7; tick();
    check("full_ready", 32'(a_in_ready), 32'h0);
    a_in_idx = 3'd1; tick();
    check("full_level", 32'(a_level), 32'h2);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    check("pop1_ready", 32'(a_in_ready), 32'h1);
    tick();
    a_out_ready = 1'b0;

    // Full with simultaneous in_valid/out_ready: pop only, then push+pop next edge.
    a_in_valid = 1'b1; a_in_idx = 3'd3; tick();
    a_in_idx = 3'd7; tick();
    a_in_idx = 3'd1; a_out_ready = 1'b1;
    tick();
    check("nowt_level", 32'(a_level), 32'h1);
    check("nowt_head",  32'(a_out_onehot), 32'h80);
    tick();
    check("pp_level", 32'(a_level), 32'h1);
    check("pp_head",  32'(a_out_onehot), 32'h02);
    a_in_valid = 1'b0;
    tick();
    a_out_ready = 1'b0;

    // WIDTH=6: idx 6 dropped with one-cycle error, idx 2 stored.
    b_in_valid = 1'b1; b_in_idx = 3'd6; tick();
    check("bad6_err", 32'(b_err_pulse), 32'h1);
    b_in_idx = 3'd2; tick();
    check("good2_err",    32'(b_err_pulse), 32'h0);
    check("good2_onehot", 32'(b_out_onehot), 32'h04);
    check("good2_level",  32'(b_level), 32'h1);
    // Consecutive bad indices pulse on consecutive cycles.
    b_out_ready = 1'b1;
    b_in_idx = 3'd7; tick();
    b_in_idx = 3'd6; tick();
    check("bad_bad_err", 32'(b_err_pulse), 32'h1);
    b_in_valid = 1'b0; tick();
    b_out_ready = 1'b0;

    // Asynchronous reset mid-cycle with two entries stored.
    a_in_valid = 1'b1; a_in_idx = 3'd5; tick();
    a_in_idx = 3'd2; tick();
    a_in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(a_out_valid), 32'h0);
    check("arst_level",  32'(a_level), 32'h0);
    check("arst_onehot", 32'(a_out_onehot), 32'h0);
    check("arst_ready",  32'(a_in_ready), 32'h0);
    qa.delete(); qb.delete(); exp_err_b = 1'b0;
`ifdef PRIO_DEC_ERR_CNT_EN
    exp_cnt_b = 0;
`endif
    #2 rst_n = 1'b1;
    #1;
    check("arst_rel_ready", 32'(a_in_ready), 32'h1);
    tick();

`ifdef PRIO_DEC_ERR_CNT_EN
    // Saturating error counter, then clear colliding with a bad push.
    b_in_valid = 1'b1; b_in_idx = 3'd7;
    repeat (300) tick();
    check("cnt_sat", 32'(b_err_count), 32'd255);
    b_err_clr = 1'b1;
    tick();
    b_err_clr = 1'b0;
    check("cnt_clr", 32'(b_err_count), 32'd0);
    b_in_valid = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
